// File: rtl/alu_ctrl_pkg.sv
// ALU control codes and execute-unit FSM encoding, shared with the ALU control decoder.
package alu_ctrl_pkg;

    typedef logic [2:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_NOP = 3'b000;
    localparam alu_ctrl_t ALU_ADD = 3'b001;
    localparam alu_ctrl_t ALU_SUB = 3'b010;
    localparam alu_ctrl_t ALU_MUL = 3'b011;
    localparam alu_ctrl_t ALU_AND = 3'b100;
    localparam alu_ctrl_t ALU_XOR = 3'b101;
    localparam alu_ctrl_t ALU_SLL = 3'b110;
    localparam alu_ctrl_t ALU_SRA = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/ex_alu_unit_mul_iter.sv
// Iterative shift-add multiplier retiring BITS multiplier bits per cycle.
// MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier is zero.
module mul_iter #(
    parameter int DATA_W = 32,
    parameter int BITS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] mcand_i,
    input  logic [DATA_W-1:0] mplier_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int STEPS = DATA_W / BITS;
    localparam int CNT_W = $clog2(STEPS);

    logic              busy_q, busy_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] partial;
    logic [DATA_W-1:0] acc_sum;
    logic              last_step;

    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
        acc_sum = acc_q + partial;
`ifdef MUL_EARLY_TERM_EN
        last_step = (cnt_q == CNT_W'(STEPS - 1)) || ((mplier_q >> BITS) == '0);
`else
        last_step = (cnt_q == CNT_W'(STEPS - 1));
`endif
    end

    assign done_o    = busy_q & last_step;
    assign product_o = acc_sum;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        busy_d   = busy_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            busy_d   = 1'b1;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (busy_q) begin
            if (flush_i) begin
                busy_d = 1'b0;
            end else begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << BITS;
                mplier_d = mplier_q >> BITS;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_step) busy_d = 1'b0;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: registered single-cycle ops plus an iterative MUL that stalls the pipe.
// MUL_EARLY_TERM_EN (see mul_iter) shortens multiplies with small multipliers.
module ex_alu_unit
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W             = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [2:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int SH_W = $clog2(DATA_W);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] alu_res;
    logic [SH_W-1:0]   shamt;
    logic              accept;
    logic              is_mul;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign shamt   = data2_i[SH_W-1:0];
    assign is_mul  = (ALUCtrl_i == ALU_MUL);
    assign ready_o = (state_q == IDLE);
    assign accept  = valid_i & ready_o & ~flush_i;

    // Stall drops in the completion cycle so upstream advances exactly once per multiply.
    assign stall_o = ((state_q == BUSY) & ~mul_done)
                   | ((state_q == IDLE) & valid_i & is_mul & ~flush_i);

    always_comb begin
        case (ALUCtrl_i)
            ALU_ADD: alu_res = data1_i + data2_i;
            ALU_SUB: alu_res = data1_i - data2_i;
            ALU_AND: alu_res = data1_i & data2_i;
            ALU_XOR: alu_res = data1_i ^ data2_i;
            ALU_SLL: alu_res = data1_i << shamt;
            ALU_SRA: alu_res = DATA_W'($signed(data1_i) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    mul_iter #(
        .DATA_W (DATA_W),
        .BITS   (MUL_BITS_PER_CYCLE)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (accept & is_mul),
        .flush_i   (flush_i),
        .mcand_i   (data1_i),
        .mplier_i  (data2_i),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = BUSY;
                    end else begin
                        result_d = alu_res;
                        done_d   = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Flush wins over a completion on the same edge.
                if (flush_i) begin
                    state_d = IDLE;
                end else if (mul_done) begin
                    state_d  = IDLE;
                    result_d = mul_product;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
